// File: rtl/sparse_pe_pkg.sv
// Shared types and default parameters for the sparse processing-element cell.
package sparse_pe_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_BLOCK_WIDTH = 4;
  localparam int DEF_ACC_WIDTH   = 32;
  localparam int DEF_SATURATE    = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_FWD
  } pe_state_e;

  // Index width for a lane/element select; never zero so a 1-wide block still gets a bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sparse_lead_one.sv
// Lowest-set-bit encoder: picks the next nonzero element to process.
module sparse_lead_one #(
  parameter int BLOCK_WIDTH = 4,
  parameter int IDX_W       = 2
) (
  input  logic [BLOCK_WIDTH-1:0] mask,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = BLOCK_WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparse_pe_cell.sv
// Sparse multiply-accumulate cell: one nonzero activation per cycle into
// per-lane accumulators, with a pass-through path for a neighbour's result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a beat; takes a chain result when no beat offered
// ST_SCAN  | one set mask bit consumed per cycle into its lane
// ST_DRAIN | local accumulators presented; cleared on handshake
// ST_FWD   | registered neighbour result presented; accumulators kept
module sparse_pe_cell
  import sparse_pe_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int SATURATE    = DEF_SATURATE
) (
  input  logic                              Clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BLOCK_WIDTH*DATA_WIDTH-1:0] in_act,
  input  logic [BLOCK_WIDTH-1:0]            in_mask,
  input  logic [DATA_WIDTH-1:0]             in_weight,
  input  logic                              in_last,
  input  logic                              Direction,
  input  logic                              chain_valid,
  output logic                              chain_ready,
  input  logic [BLOCK_WIDTH*ACC_WIDTH-1:0]  chain_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BLOCK_WIDTH*ACC_WIDTH-1:0]  out_data,
  output logic                              out_src,
  output logic                              out_ovf
);

  localparam int IDX_W = idx_width(BLOCK_WIDTH);

  pe_state_e state, state_nxt;

  logic [BLOCK_WIDTH*DATA_WIDTH-1:0] act_q;
  logic [BLOCK_WIDTH-1:0]            mask_q;
  logic signed [DATA_WIDTH-1:0]      weight_q;
  logic                              last_q;
  logic                              dir_q;
  logic [BLOCK_WIDTH*ACC_WIDTH-1:0]  chain_q;
  logic signed [ACC_WIDTH-1:0]       acc [BLOCK_WIDTH];
  logic                              ovf_q;

  logic [IDX_W-1:0]                sel_idx;
  logic                            sel_any;
  logic [IDX_W-1:0]                sel_lane;
  logic signed [DATA_WIDTH-1:0]    sel_act;
  logic signed [2*DATA_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]     acc_sel;
  logic signed [ACC_WIDTH:0]       sum_wide;
  logic signed [ACC_WIDTH-1:0]     sum_acc;
  logic                            sum_ovf;
  logic [BLOCK_WIDTH-1:0]          mask_clr;
  logic                            accept;
  logic                            take_chain;

  assign accept     = (state == ST_IDLE) && in_valid;
  assign take_chain = (state == ST_IDLE) && !in_valid && chain_valid;

  sparse_lead_one #(
    .BLOCK_WIDTH(BLOCK_WIDTH),
    .IDX_W      (IDX_W)
  ) u_lead_one (
    .mask(mask_q),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Multiply the selected element, add into its lane with one guard bit, clamp or wrap.
  always_comb begin
    sel_act = '0;
    for (int i = 0; i < BLOCK_WIDTH; i++) begin
      if (IDX_W'(i) == sel_idx) sel_act = act_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
    sel_lane = dir_q ? (IDX_W'(BLOCK_WIDTH - 1) - sel_idx) : sel_idx;
    prod     = sel_act * weight_q;
    acc_sel  = acc[sel_lane];
    sum_wide = {acc_sel[ACC_WIDTH-1], acc_sel}
             + {{(ACC_WIDTH + 1 - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    sum_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    if (sum_ovf && (SATURATE != 0))
      sum_acc = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      sum_acc = sum_wide[ACC_WIDTH-1:0];
    mask_clr = mask_q & ~(BLOCK_WIDTH'(1) << sel_idx);
  end

  // Next-state and handshake/output decode.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    chain_ready = 1'b0;
    out_valid   = 1'b0;
    out_src     = 1'b0;
    out_ovf     = 1'b0;
    out_data    = '0;
    for (int k = 0; k < BLOCK_WIDTH; k++) begin
      out_data[k*ACC_WIDTH +: ACC_WIDTH] = acc[k];
    end
    unique case (state)
      ST_IDLE: begin
        in_ready    = 1'b1;
        chain_ready = !in_valid;
        out_ovf     = ovf_q;
        if (in_valid) begin
          if (in_mask != '0)  state_nxt = ST_SCAN;
          else if (in_last)   state_nxt = ST_DRAIN;
        end else if (chain_valid) begin
          state_nxt = ST_FWD;
        end
      end
      ST_SCAN: begin
        out_ovf = ovf_q;
        if (mask_clr == '0) state_nxt = last_q ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_ovf   = ovf_q;
        if (out_ready) state_nxt = ST_IDLE;
      end
      ST_FWD: begin
        out_valid = 1'b1;
        out_src   = 1'b1;
        out_data  = chain_q;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Beat capture; the mask doubles as the SCAN work list.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      act_q    <= '0;
      mask_q   <= '0;
      weight_q <= '0;
      last_q   <= 1'b0;
      dir_q    <= 1'b0;
    end else if (accept) begin
      act_q    <= in_act;
      mask_q   <= in_mask;
      weight_q <= in_weight;
      last_q   <= in_last;
      dir_q    <= Direction;
    end else if (state == ST_SCAN) begin
      mask_q <= mask_clr;
    end
  end

  // Neighbour result register, loaded only when the chain handshake wins.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst)            chain_q <= '0;
    else if (take_chain) chain_q <= chain_in;
  end

  // Lane accumulators and sticky overflow, cleared when a local result is consumed.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < BLOCK_WIDTH; k++) acc[k] <= '0;
      ovf_q <= 1'b0;
    end else if (state == ST_DRAIN && out_ready) begin
      for (int k = 0; k < BLOCK_WIDTH; k++) acc[k] <= '0;
      ovf_q <= 1'b0;
    end else if (state == ST_SCAN && sel_any) begin
      for (int k = 0; k < BLOCK_WIDTH; k++) begin
        if (IDX_W'(k) == sel_lane) acc[k] <= sum_acc;
      end
      if (sum_ovf) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sparse_pe_cell.sv
// Directed bench: default cell plus 16-bit saturating and wrapping cells on shared stimulus.
module tb_sparse_pe_cell;

  localparam logic [127:0] PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic         Clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_act = '0;
  logic [3:0]   in_mask = '0;
  logic [7:0]   in_weight = '0;
  logic         in_last = 1'b0;
  logic         Direction = 1'b0;
  logic         chain_valid = 1'b0;
  logic [127:0] chain_in = '0;
  logic         out_ready = 1'b0;

  logic         in_ready_a, chain_ready_a, out_valid_a, out_src_a, out_ovf_a;
  logic [127:0] out_data_a;
  logic         in_ready_s, chain_ready_s, out_valid_s, out_src_s, out_ovf_s;
  logic [63:0]  out_data_s;
  logic         in_ready_w, chain_ready_w, out_valid_w, out_src_w, out_ovf_w;
  logic [63:0]  out_data_w;

  int total = 0;
  int bad   = 0;
  int cyc;

  always #5 Clk = ~Clk;

  sparse_pe_cell dut_a (
    .Clk(Clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_act(in_act), .in_mask(in_mask), .in_weight(in_weight), .in_last(in_last),
    .Direction(Direction), .chain_valid(chain_valid), .chain_ready(chain_ready_a),
    .chain_in(chain_in), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_src(out_src_a), .out_ovf(out_ovf_a)
  );

  sparse_pe_cell #(.ACC_WIDTH(16), .SATURATE(1)) dut_s (
    .Clk(Clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_act(in_act), .in_mask(in_mask), .in_weight(in_weight), .in_last(in_last),
    .Direction(Direction), .chain_valid(chain_valid), .chain_ready(chain_ready_s),
    .chain_in(chain_in[63:0]), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_src(out_src_s), .out_ovf(out_ovf_s)
  );

  sparse_pe_cell #(.ACC_WIDTH(16), .SATURATE(0)) dut_w (
    .Clk(Clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_act(in_act), .in_mask(in_mask), .in_weight(in_weight), .in_last(in_last),
    .Direction(Direction), .chain_valid(chain_valid), .chain_ready(chain_ready_w),
    .chain_in(chain_in[63:0]), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_data(out_data_w), .out_src(out_src_w), .out_ovf(out_ovf_w)
  );

  task automatic send_beat(input logic [31:0] act, input logic [3:0] mask,
                           input logic [7:0] w, input logic last, input logic dir);
    @(negedge Clk);
    in_valid  = 1'b1;
    in_act    = act;
    in_mask   = mask;
    in_weight = w;
    in_last   = last;
    Direction = dir;
    @(posedge Clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts SCAN negedges until the cell presents a result or returns to IDLE; 999 on timeout.
  task automatic wait_done(output int cycles);
    cycles = 999;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clk);
      if (out_valid_a || in_ready_a) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic drain_out();
    out_ready = 1'b1;
    @(posedge Clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_a); end
    total++; if (chain_ready_a !== 1'b1) begin bad++; $display("FAIL reset_chain_ready got=%b exp=1", chain_ready_a); end
    total++; if ({out_valid_a, out_src_a, out_ovf_a} !== 3'b000) begin bad++; $display("FAIL reset_flags_a got=%b exp=000", {out_valid_a, out_src_a, out_ovf_a}); end
    total++; if (out_data_a !== 128'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data_a); end
    total++; if ({in_ready_s, chain_ready_s, out_valid_s, out_src_s, out_ovf_s} !== 5'b11000) begin bad++; $display("FAIL reset_flags_s got=%b exp=11000", {in_ready_s, chain_ready_s, out_valid_s, out_src_s, out_ovf_s}); end
    total++; if ({in_ready_w, chain_ready_w, out_valid_w, out_src_w, out_ovf_w} !== 5'b11000) begin bad++; $display("FAIL reset_flags_w got=%b exp=11000", {in_ready_w, chain_ready_w, out_valid_w, out_src_w, out_ovf_w}); end
    rst = 1'b1;
  endtask

  task automatic test_dense();
    send_beat({8'd4, 8'd3, 8'd2, 8'd1}, 4'b1111, 8'd2, 1'b1, 1'b0);
    wait_done(cyc);
    total++; if (cyc != 4) begin bad++; $display("FAIL dense_scan_cycles got=%0d exp=4", cyc); end
    total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL dense_valid got=%b exp=1", out_valid_a); end
    total++; if (out_data_a !== {32'd8, 32'd6, 32'd4, 32'd2}) begin bad++; $display("FAIL dense_data got=%h exp=%h", out_data_a, {32'd8, 32'd6, 32'd4, 32'd2}); end
    total++; if ({out_src_a, out_ovf_a} !== 2'b00) begin bad++; $display("FAIL dense_src_ovf got=%b exp=00", {out_src_a, out_ovf_a}); end
    drain_out();
    @(negedge Clk);
    total++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin bad++; $display("FAIL dense_after_drain valid=%b ready=%b exp 0/1", out_valid_a, in_ready_a); end
  endtask

  task automatic test_sparse_reversed();
    send_beat({8'hFD, 8'd0, 8'd0, 8'd5}, 4'b1001, 8'd3, 1'b1, 1'b1);
    wait_done(cyc);
    total++; if (cyc != 2) begin bad++; $display("FAIL sparse_scan_cycles got=%0d exp=2", cyc); end
    total++; if (out_data_a !== {32'd15, 32'd0, 32'd0, 32'hFFFF_FFF7}) begin bad++; $display("FAIL sparse_data got=%h exp=%h", out_data_a, {32'd15, 32'd0, 32'd0, 32'hFFFF_FFF7}); end
    total++; if (out_data_s !== {16'd15, 16'd0, 16'd0, 16'hFFF7}) begin bad++; $display("FAIL sparse_data_s got=%h exp=%h", out_data_s, {16'd15, 16'd0, 16'd0, 16'hFFF7}); end
    drain_out();
  endtask

  task automatic test_empty();
    send_beat(32'h0505_0505, 4'b0000, 8'd9, 1'b0, 1'b0);
    @(negedge Clk);
    total++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin bad++; $display("FAIL empty_nolast ready=%b valid=%b exp 1/0", in_ready_a, out_valid_a); end
    send_beat(32'h0505_0505, 4'b0000, 8'd9, 1'b1, 1'b0);
    wait_done(cyc);
    total++; if (cyc != 0 || out_valid_a !== 1'b1) begin bad++; $display("FAIL empty_last_latency cycles=%0d valid=%b exp 0/1", cyc, out_valid_a); end
    total++; if (out_data_a !== 128'd0) begin bad++; $display("FAIL empty_data got=%h exp=0", out_data_a); end
    drain_out();
  endtask

  task automatic test_arb_fwd();
    @(negedge Clk);
    in_valid = 1'b1; in_act = 32'd7; in_mask = 4'b0001; in_weight = 8'd2;
    in_last = 1'b0; Direction = 1'b0; chain_valid = 1'b1; chain_in = PAT;
    #1;
    total++; if (chain_ready_a !== 1'b0 || in_ready_a !== 1'b1) begin bad++; $display("FAIL arb_both chain_ready=%b in_ready=%b exp 0/1", chain_ready_a, in_ready_a); end
    @(posedge Clk);
    #1 in_valid = 1'b0;
    @(negedge Clk);
    total++; if (in_ready_a !== 1'b0 || chain_ready_a !== 1'b0) begin bad++; $display("FAIL arb_beat_taken in_ready=%b chain_ready=%b exp 0/0", in_ready_a, chain_ready_a); end
    @(negedge Clk);
    total++; if (chain_ready_a !== 1'b1) begin bad++; $display("FAIL arb_chain_ready got=%b exp=1", chain_ready_a); end
    @(posedge Clk);
    #1 chain_valid = 1'b0;
    chain_in = ~PAT;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      total++;
      if (out_valid_a !== 1'b1 || out_src_a !== 1'b1 || out_ovf_a !== 1'b0 || out_data_a !== PAT) begin
        bad++;
        $display("FAIL fwd_hold_%0d valid=%b src=%b ovf=%b data=%h exp 1/1/0/%h", i, out_valid_a, out_src_a, out_ovf_a, out_data_a, PAT);
      end
    end
    total++; if (out_data_s !== PAT[63:0]) begin bad++; $display("FAIL fwd_data_s got=%h exp=%h", out_data_s, PAT[63:0]); end
    drain_out();
    send_beat(32'd0, 4'b0000, 8'd0, 1'b1, 1'b0);
    wait_done(cyc);
    total++; if (out_data_a !== {96'd0, 32'd14} || out_src_a !== 1'b0) begin bad++; $display("FAIL fwd_acc_kept data=%h src=%b exp=%h/0", out_data_a, out_src_a, {96'd0, 32'd14}); end
    drain_out();
  endtask

  task automatic test_reset_mid_scan();
    send_beat(32'h0101_0101, 4'b1111, 8'd1, 1'b1, 1'b0);
    repeat (2) @(negedge Clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_mid_async ready=%b valid=%b exp 1/0", in_ready_a, out_valid_a); end
    @(negedge Clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_mid_no_output_%0d got=%b exp=0", i, out_valid_a); end
    end
    send_beat(32'd3, 4'b0001, 8'd1, 1'b1, 1'b0);
    wait_done(cyc);
    total++; if (cyc != 1 || out_data_a !== {96'd0, 32'd3}) begin bad++; $display("FAIL rst_mid_fresh cycles=%0d data=%h exp 1/%h", cyc, out_data_a, {96'd0, 32'd3}); end
    drain_out();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 599; i++) begin
      send_beat(32'h0000_007F, 4'b0001, 8'd127, 1'b0, 1'b0);
      wait_done(cyc);
    end
    send_beat(32'h0000_007F, 4'b0001, 8'd127, 1'b1, 1'b0);
    wait_done(cyc);
    total++; if (cyc != 1 || out_valid_s !== 1'b1) begin bad++; $display("FAIL sat_latency cycles=%0d valid=%b exp 1/1", cyc, out_valid_s); end
    total++; if (out_data_s !== {48'd0, 16'h7FFF} || out_ovf_s !== 1'b1) begin bad++; $display("FAIL sat_clamp data=%h ovf=%b exp=%h/1", out_data_s, out_ovf_s, {48'd0, 16'h7FFF}); end
    total++; if (out_data_w !== {48'd0, 16'hAA58} || out_ovf_w !== 1'b1) begin bad++; $display("FAIL wrap_value data=%h ovf=%b exp=%h/1", out_data_w, out_ovf_w, {48'd0, 16'hAA58}); end
    total++; if (out_data_a !== {96'd0, 32'h0093_AA58} || out_ovf_a !== 1'b0) begin bad++; $display("FAIL wide_no_ovf data=%h ovf=%b exp=%h/0", out_data_a, out_ovf_a, {96'd0, 32'h0093_AA58}); end
    drain_out();
    send_beat(32'd0, 4'b0000, 8'd0, 1'b1, 1'b0);
    wait_done(cyc);
    total++; if (out_valid_s !== 1'b1 || out_ovf_s !== 1'b0 || out_data_s !== 64'd0) begin bad++; $display("FAIL sat_cleared valid=%b ovf=%b data=%h exp 1/0/0", out_valid_s, out_ovf_s, out_data_s); end
    total++; if (out_ovf_w !== 1'b0 || out_data_w !== 64'd0) begin bad++; $display("FAIL wrap_cleared ovf=%b data=%h exp 0/0", out_ovf_w, out_data_w); end
    drain_out();
  endtask

  initial begin
    test_reset();
    test_dense();
    test_sparse_reversed();
    test_empty();
    test_arb_fwd();
    test_reset_mid_scan();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
